// File: rtl/bin_to_sevenseg_display.sv
`default_nettype none
// ============================================================================
// Module   : bin_to_sevenseg_display
// Desc     : Registered multi-digit seven-segment driver; sequential
//            binary-to-BCD (shift-and-add-3), leading-zero blanking, overflow
//            dashes. Macro SEVSEG_SIGNED_EN selects two's-complement input.
// Revision : 1.0 - initial release
// ============================================================================
module bin_to_sevenseg_display #(
  parameter int NUM_DIGITS = 8,
  parameter int BIN_WIDTH  = 27
) (
  input  logic                    clock,
  input  logic                    reset_L,
  input  logic [BIN_WIDTH-1:0]    in_value,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    lz_blank,
  input  logic [NUM_DIGITS-1:0]   turn_on,
  output logic [7*NUM_DIGITS-1:0] hex_out,
  output logic                    overflow,
  output logic                    update
);

  localparam int c_bcd_w = 4 * NUM_DIGITS;
  localparam int c_cnt_w = $clog2(BIN_WIDTH);

  localparam logic [1:0] c_idle    = 2'd0;
  localparam logic [1:0] c_convert = 2'd1;
  localparam logic [1:0] c_commit  = 2'd2;

  logic [1:0]              r_state;
  logic [c_cnt_w-1:0]      r_cnt;
  logic [BIN_WIDTH-1:0]    r_bin;
  logic [c_bcd_w-1:0]      r_bcd;
  logic                    r_lz;
  logic                    r_ovf_acc;
  logic [7*NUM_DIGITS-1:0] r_seg;
  logic                    r_ovf;
  logic                    r_update;

  logic [BIN_WIDTH-1:0]    w_mag;
  logic [c_bcd_w-1:0]      w_bcd_adj;
  logic                    w_ovf_next;
  logic [NUM_DIGITS-1:0]   w_shown;
  logic [NUM_DIGITS-1:0]   w_minus;
  logic [7*NUM_DIGITS-1:0] w_seg_next;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'h40;
      4'd1:    seg7 = 7'h79;
      4'd2:    seg7 = 7'h24;
      4'd3:    seg7 = 7'h30;
      4'd4:    seg7 = 7'h19;
      4'd5:    seg7 = 7'h12;
      4'd6:    seg7 = 7'h02;
      4'd7:    seg7 = 7'h78;
      4'd8:    seg7 = 7'h00;
      4'd9:    seg7 = 7'h18;
      default: seg7 = 7'h7F;
    endcase
  endfunction

`ifdef SEVSEG_SIGNED_EN
  logic r_neg;
  // Magnitude of the most negative value is still correct read as unsigned.
  assign w_mag      = in_value[BIN_WIDTH-1] ? -in_value : in_value;
  assign w_ovf_next = r_ovf_acc | (r_neg & (|r_bcd[c_bcd_w-1 -: 4]));
`else
  assign w_mag      = in_value;
  assign w_ovf_next = r_ovf_acc;
`endif

  always_comb begin
    w_bcd_adj = r_bcd;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (r_bcd[4*i +: 4] >= 4'd5) begin
        w_bcd_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      r_state   <= c_idle;
      r_cnt     <= '0;
      r_bin     <= '0;
      r_bcd     <= '0;
      r_lz      <= 1'b0;
      r_ovf_acc <= 1'b0;
      r_seg     <= {NUM_DIGITS{7'h7F}};
      r_ovf     <= 1'b0;
      r_update  <= 1'b0;
`ifdef SEVSEG_SIGNED_EN
      r_neg     <= 1'b0;
`endif
    end else begin
      r_update <= 1'b0;
      case (r_state)
        c_idle: begin
          if (in_valid) begin
            r_bin     <= w_mag;
            r_lz      <= lz_blank;
            r_bcd     <= '0;
            r_ovf_acc <= 1'b0;
            r_cnt     <= c_cnt_w'(BIN_WIDTH - 1);
            r_state   <= c_convert;
`ifdef SEVSEG_SIGNED_EN
            r_neg     <= in_value[BIN_WIDTH-1];
`endif
          end
        end
        c_convert: begin
          // A carry out of the top nibble means the value needs another digit.
          r_bcd     <= {w_bcd_adj[c_bcd_w-2:0], r_bin[BIN_WIDTH-1]};
          r_bin     <= {r_bin[BIN_WIDTH-2:0], 1'b0};
          r_ovf_acc <= r_ovf_acc | w_bcd_adj[c_bcd_w-1];
          if (r_cnt == '0) begin
            r_state <= c_commit;
          end else begin
            r_cnt <= r_cnt - c_cnt_w'(1);
          end
        end
        c_commit: begin
          r_seg    <= w_seg_next;
          r_ovf    <= w_ovf_next;
          r_update <= 1'b1;
          r_state  <= c_idle;
        end
        default: r_state <= c_idle;
      endcase
    end
  end

  generate
    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
      if (i == 0) begin : g_lsd
        assign w_shown[i] = 1'b1;
        assign w_minus[i] = 1'b0;
      end else begin : g_upper
        assign w_shown[i] = ~r_lz | (|r_bcd[c_bcd_w-1:4*i]);
`ifdef SEVSEG_SIGNED_EN
        // Minus sits just left of the most significant shown digit.
        assign w_minus[i] = r_neg & (r_lz
                            ? (~(|r_bcd[c_bcd_w-1:4*i]) & ((i == 1) | (|r_bcd[4*i-4 +: 4])))
                            : (i == NUM_DIGITS - 1));
`else
        assign w_minus[i] = 1'b0;
`endif
      end
      assign w_seg_next[7*i +: 7] = (w_ovf_next | w_minus[i]) ? 7'h3F
                                  : (w_shown[i] ? seg7(r_bcd[4*i +: 4]) : 7'h7F);
      assign hex_out[7*i +: 7]    = turn_on[i] ? r_seg[7*i +: 7] : 7'h7F;
    end
  endgenerate

  assign in_ready = (r_state == c_idle);
  assign overflow = r_ovf;
  assign update   = r_update;

endmodule
`default_nettype wire

// File: tb/tb_bin_to_sevenseg_display.sv
`default_nettype none
// Self-checking bench for bin_to_sevenseg_display: directed and random values
// compared against a decimal-arithmetic display model.
module tb_bin_to_sevenseg_display;
  localparam int ND  = 8;
  localparam int BW  = 27;
  localparam int LAT = BW + 1;

  logic            clock = 1'b0;
  logic            reset_L;
  logic [BW-1:0]   in_value;
  logic            in_valid;
  logic            in_ready;
  logic            lz_blank;
  logic [ND-1:0]   turn_on;
  logic [7*ND-1:0] hex_out;
  logic            overflow;
  logic            update;

  int tests = 0;
  int fails = 0;
  logic [6:0] seg_tbl [10];

  always #5 clock = ~clock;

  bin_to_sevenseg_display #(.NUM_DIGITS(ND), .BIN_WIDTH(BW)) dut (
    .clock(clock), .reset_L(reset_L), .in_value(in_value), .in_valid(in_valid),
    .in_ready(in_ready), .lz_blank(lz_blank), .turn_on(turn_on),
    .hex_out(hex_out), .overflow(overflow), .update(update)
  );

  function automatic void model(input logic [BW-1:0] raw, input logic lz,
                                input logic [ND-1:0] ton,
                                output logic [7*ND-1:0] h, output logic o);
    longint v, mag, lim;
    int d[ND];
    int msd;
    bit neg;
    logic [6:0] s;
`ifdef SEVSEG_SIGNED_EN
    v = longint'($signed(raw));
`else
    v = longint'(raw);
`endif
    neg = (v < 0);
    mag = neg ? -v : v;
    lim = 1;
    for (int i = 0; i < (neg ? ND - 1 : ND); i++) lim = lim * 10;
    o = (mag >= lim);
    msd = 0;
    for (int i = 0; i < ND; i++) begin
      d[i] = int'(mag % 10);
      mag  = mag / 10;
      if (d[i] != 0) msd = i;
    end
    for (int i = 0; i < ND; i++) begin
      if (o) s = 7'h3F;
      else if (neg && ((lz && i == msd + 1) || (!lz && i == ND - 1))) s = 7'h3F;
      else if (lz && i > msd) s = 7'h7F;
      else s = seg_tbl[d[i]];
      h[7*i +: 7] = ton[i] ? s : 7'h7F;
    end
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [BW-1:0] v, input logic lz, input string tag);
    logic [7*ND-1:0] prev, eh;
    logic eo;
    int k, w;
    bit held;
    w = 0;
    @(negedge clock);
    while (!in_ready && w < 100) begin
      @(negedge clock);
      w++;
    end
    chk({tag, "/ready"}, 64'(in_ready), 64'(1));
    in_value = v;
    lz_blank = lz;
    in_valid = 1'b1;
    @(negedge clock);
    in_valid = 1'b0;
    in_value = BW'($urandom);
    lz_blank = 1'($urandom);
    prev = hex_out;
    held = 1'b1;
    k = 0;
    while (!update && k < 100) begin
      if (hex_out !== prev || in_ready !== 1'b0) held = 1'b0;
      @(negedge clock);
      k++;
    end
    chk({tag, "/latency"}, 64'(k), 64'(LAT));
    chk({tag, "/held"}, 64'(held), 64'(1));
    model(v, lz, turn_on, eh, eo);
    chk({tag, "/hex"}, 64'(hex_out), 64'(eh));
    chk({tag, "/ovf"}, 64'(overflow), 64'(eo));
    @(negedge clock);
    chk({tag, "/pulse"}, 64'(update), 64'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7*ND-1:0] eh;
    logic eo;
    logic [BW-1:0] rv;
    logic rl;
    int n, cyc, k;
    int acc[3];
    bit pend, ok;

    seg_tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h18};
    reset_L = 1'b0; in_valid = 1'b0; in_value = '0; lz_blank = 1'b0; turn_on = '1;
    repeat (3) @(negedge clock);
    reset_L = 1'b1;
    @(negedge clock);
    chk("reset/hex", 64'(hex_out), 64'({ND{7'h7F}}));
    chk("reset/ready", 64'(in_ready), 64'(1));
    chk("reset/ovf", 64'(overflow), 64'(0));
    chk("reset/update", 64'(update), 64'(0));

    send(BW'(12345678), 1'b0, "digits");
    send(BW'(0), 1'b1, "zero_lz");
    send(BW'(907), 1'b1, "907_lz");
    send(BW'(100000000), 1'b0, "ovf_min");
    send(BW'(99999999), 1'b1, "max_fit");

    // Abort a conversion with reset ten clocks in.
    @(negedge clock);
    in_value = BW'(42); lz_blank = 1'b0; in_valid = 1'b1;
    @(negedge clock);
    in_valid = 1'b0;
    repeat (9) @(negedge clock);
    #2 reset_L = 1'b0;
    #1;
    chk("abort/hex", 64'(hex_out), 64'({ND{7'h7F}}));
    chk("abort/ready", 64'(in_ready), 64'(1));
    chk("abort/ovf", 64'(overflow), 64'(0));
    @(negedge clock);
    reset_L = 1'b1;
    ok = 1'b1;
    repeat (40) begin
      @(negedge clock);
      if (update !== 1'b0 || hex_out !== {ND{7'h7F}}) ok = 1'b0;
    end
    chk("abort/quiet", 64'(ok), 64'(1));
    send(BW'(5), 1'b0, "after_abort");

    // in_valid held high across three accepts.
    turn_on = 8'h01;
    @(negedge clock);
    in_value = BW'(1); lz_blank = 1'b0; in_valid = 1'b1;
    n = 0; cyc = 0; pend = 1'b0;
    while (cyc < 300) begin
      if (pend) begin in_value = BW'(n + 1); pend = 1'b0; end
      if (in_ready) begin acc[n] = cyc; n++; pend = 1'b1; end
      if (n == 3) break;
      @(negedge clock);
      cyc++;
    end
    chk("stream/count", 64'(n), 64'(3));
    @(negedge clock);
    in_valid = 1'b0;
    k = 0;
    while (!update && k < 100) begin @(negedge clock); k++; end
    chk("stream/gap1", 64'(acc[1] - acc[0]), 64'(BW + 2));
    chk("stream/gap2", 64'(acc[2] - acc[1]), 64'(BW + 2));
    model(BW'(3), 1'b0, turn_on, eh, eo);
    chk("stream/hex", 64'(hex_out), 64'(eh));

    turn_on = '1;
`ifdef SEVSEG_SIGNED_EN
    send(BW'(-305), 1'b1, "neg305_lz");
    send(BW'(-9999999), 1'b0, "neg_max");
    send({1'b1, {(BW-1){1'b0}}}, 1'b0, "neg_most");
`endif

    for (int i = 0; i < 10; i++) begin
      case ($urandom_range(0, 3))
        0:       rv = BW'($urandom_range(0, 999));
        1:       rv = BW'($urandom);
        2:       rv = BW'($urandom_range(99999990, 100000010));
        default: rv = BW'($urandom_range(0, 99999999));
      endcase
      rl = 1'($urandom);
      turn_on = ND'($urandom);
      send(rv, rl, "random");
      turn_on = ND'($urandom);
      #1;
      model(rv, rl, turn_on, eh, eo);
      chk("random/mask", 64'(hex_out), 64'(eh));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
`default_nettype wire
